clk_period_monitor: RTL and testbench
=====================================

CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all time counters and measurement outputs.
REQ-002 SHALL have parameter EXP_PERIOD, default 10, expected period in clk cycles.
REQ-003 SHALL have parameter EXP_HIGH, default 5, expected high time in clk cycles.
REQ-004 SHALL have parameter TOL, default 1, allowed absolute deviation in clk cycles.
REQ-005 SHALL have parameter TIMEOUT, default 64, phase length in clk cycles that declares the monitored clock stopped.
REQ-006 SHALL have port clk, input, 1 bit: sampling clock, the only clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1 bit: monitoring enable.
REQ-009 SHALL have port mon_in, input, 1 bit: monitored clock, asynchronous to clk.
REQ-010 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when new results are available.
REQ-011 SHALL have port period, output, CNT_W bits: last measured period.
REQ-012 SHALL have port high_time, output, CNT_W bits: last measured high time.
REQ-013 SHALL have port jitter, output, CNT_W bits: |period - EXP_PERIOD|.
REQ-014 SHALL have port period_err, output, 1 bit: jitter > TOL.
REQ-015 SHALL have port duty_err, output, 1 bit: |high_time - EXP_HIGH| > TOL.
REQ-016 SHALL have port stuck, output, 1 bit: no edge seen for TIMEOUT cycles.
REQ-017 SHALL have port max_jitter, output, CNT_W bits: largest jitter since reset (see REQ-031).

Function
REQ-018 mon_in SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector producing rise_p and fall_p.
REQ-019 The FSM states SHALL be IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-020 Transitions SHALL be: IDLE->WAIT_RISE when enable=1; WAIT_RISE->MEAS_HIGH on rise_p; MEAS_HIGH->MEAS_LOW on fall_p; MEAS_LOW->MEAS_HIGH on rise_p; any state->IDLE when enable=0.
REQ-021 The phase counter SHALL load 1 on the entering edge pulse and increment every cycle in the phase, so that a synchronous stimulus held high for H cycles gives high_time=H.
REQ-022 On fall_p in MEAS_HIGH, the high count SHALL be latched internally.
REQ-023 On rise_p in MEAS_LOW, the block SHALL register period=high+low, high_time, jitter, period_err and duty_err, and pulse meas_valid on the next cycle.
REQ-024 The first rise after enable or reset SHALL only start a measurement; the first meas_valid SHALL follow one complete period.
REQ-025 Counters SHALL saturate at 2^CNT_W-1, and differences SHALL use absolute value without wrap.
REQ-026 If a phase count reaches TIMEOUT, stuck SHALL be set, the FSM SHALL go to WAIT_RISE, and no meas_valid SHALL be issued for that period.
REQ-027 stuck SHALL clear on the next rise_p.
REQ-028 A falling edge of enable mid-period SHALL abort without meas_valid; result outputs SHALL hold their last values.

Reset
REQ-029 On rst=1 at a clk edge, the FSM SHALL go to IDLE, and the synchronizer flops, counters and all outputs SHALL be 0.
REQ-030 Reset mid-measurement SHALL discard the partial period; the next meas_valid SHALL occur no earlier than one full period after the first post-reset rise.

Configuration
REQ-031 Macro CLK_MON_MAXJIT_EN defined: max_jitter SHALL update to max(max_jitter, jitter) on each meas_valid and clear only on rst. Macro undefined: max_jitter SHALL be tied to 0 and no tracking register SHALL exist.

Structure
REQ-032 Package clk_mon_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 Sub-module clk_mon_sync SHALL implement the synchronizer and edge detector, with outputs level, rise_p and fall_p.

Verification (EXP_PERIOD=10, EXP_HIGH=5, TOL=1, TIMEOUT=64)
REQ-034 Stimulus mon_in 5 high/5 low, repeated -> meas_valid every 10 cycles, period=10, high_time=5, jitter=0, no errors.
REQ-035 Stimulus 5 high/7 low -> period=12, jitter=2, period_err=1, duty_err=0.
REQ-036 Stimulus 8 high/2 low -> period=10, high_time=8, period_err=0, duty_err=1.
REQ-037 Stimulus mon_in held low for 70 cycles, then 5/5 -> stuck=1 at 64 cycles after the last fall; stuck clears on the next rise; the first meas_valid comes one full period after that rise.
REQ-038 Stimulus rst pulsed mid-high phase -> all outputs 0 the next cycle, no spurious meas_valid, normal results after one full period.
REQ-039 With CLK_MON_MAXJIT_EN, stimulus periods 10, 13, 9 -> max_jitter reads 0, 3, 3; without the macro -> max_jitter stays 0.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared FSM state encoding and default parameters for the clock period monitor.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEAS_HIGH = 2'd2,
      MEAS_LOW  = 2'd3
   } mon_state_e;

   localparam int CNT_W_DEF      = 16;
   localparam int EXP_PERIOD_DEF = 10;
   localparam int EXP_HIGH_DEF   = 5;
   localparam int TOL_DEF        = 1;
   localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/clk_mon_sync.sv
// Two-flop synchronizer plus one-flop edge detector for the monitored clock.
// Edge pulses appear combinationally from the registered level, 2-3 clk cycles after mon_in moves.
module clk_mon_sync (
   input  logic clk,
   input  logic rst,
   input  logic mon_in,
   output logic level,
   output logic rise_p,
   output logic fall_p
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= mon_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level  = sync_q;
   assign rise_p = sync_q & ~prev_q;
   assign fall_p = ~sync_q & prev_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period/high time of an asynchronous clock, flags jitter, duty and stuck faults.
// Results and the meas_valid pulse register on the rise closing a period; CLK_MON_MAXJIT_EN adds max-jitter tracking.
module clk_period_monitor
   import clk_mon_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int EXP_PERIOD = EXP_PERIOD_DEF,
   parameter int EXP_HIGH   = EXP_HIGH_DEF,
   parameter int TOL        = TOL_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             mon_in,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] jitter,
   output logic             period_err,
   output logic             duty_err,
   output logic             stuck,
   output logic [CNT_W-1:0] max_jitter
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] EXP_P_C   = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] EXP_H_C   = CNT_W'(EXP_HIGH);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   logic level_unused;
   logic rise_p;
   logic fall_p;

   clk_mon_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .mon_in (mon_in),
      .level  (level_unused),
      .rise_p (rise_p),
      .fall_p (fall_p)
   );

   mon_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] high_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_time_q;
   logic [CNT_W-1:0] jitter_q;
   logic             period_err_q;
   logic             duty_err_q;
   logic             stuck_q;
   logic             meas_valid_q;

   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_hit;
   logic [CNT_W:0]   sum_w;
   logic [CNT_W-1:0] period_d;
   logic [CNT_W-1:0] jitter_d;
   logic [CNT_W-1:0] hdev_d;
   logic             meas_take;

   assign cnt_inc     = sat_inc(cnt_q);
   assign timeout_hit = (cnt_inc >= TIMEOUT_C);
   // One extra bit so the sum can be clamped instead of wrapping.
   assign sum_w       = {1'b0, high_q} + {1'b0, cnt_q};
   assign period_d    = sum_w[CNT_W] ? CNT_MAX : sum_w[CNT_W-1:0];
   assign jitter_d    = abs_diff(period_d, EXP_P_C);
   assign hdev_d      = abs_diff(high_q, EXP_H_C);
   assign meas_take   = enable && (state_q == MEAS_LOW) && rise_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         high_q       <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         jitter_q     <= '0;
         period_err_q <= 1'b0;
         duty_err_q   <= 1'b0;
         stuck_q      <= 1'b0;
         meas_valid_q <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            if (rise_p) stuck_q <= 1'b0;
            case (state_q)
               IDLE: state_q <= WAIT_RISE;
               WAIT_RISE: begin
                  if (rise_p) begin
                     state_q <= MEAS_HIGH;
                     cnt_q   <= CNT_ONE;
                  end
               end
               MEAS_HIGH: begin
                  if (fall_p) begin
                     high_q  <= cnt_q;
                     cnt_q   <= CNT_ONE;
                     state_q <= MEAS_LOW;
                  end else if (timeout_hit) begin
                     stuck_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= WAIT_RISE;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               MEAS_LOW: begin
                  if (rise_p) begin
                     period_q     <= period_d;
                     high_time_q  <= high_q;
                     jitter_q     <= jitter_d;
                     period_err_q <= (jitter_d > TOL_C);
                     duty_err_q   <= (hdev_d > TOL_C);
                     meas_valid_q <= 1'b1;
                     cnt_q        <= CNT_ONE;
                     state_q      <= MEAS_HIGH;
                  end else if (timeout_hit) begin
                     stuck_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= WAIT_RISE;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef CLK_MON_MAXJIT_EN
   logic [CNT_W-1:0] max_jit_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         max_jit_q <= '0;
      end else if (meas_take && (jitter_d > max_jit_q)) begin
         max_jit_q <= jitter_d;
      end
   end

   assign max_jitter = max_jit_q;
`else
   assign max_jitter = '0;
`endif

   assign meas_valid = meas_valid_q;
   assign period     = period_q;
   assign high_time  = high_time_q;
   assign jitter     = jitter_q;
   assign period_err = period_err_q;
   assign duty_err   = duty_err_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Self-checking bench: drives mon_in waveforms and compares each meas_valid against a period-level model.
module tb_clk_period_monitor;

   localparam int EXP_P = 10;
   localparam int EXP_H = 5;
   localparam int TOLV  = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        mon_in = 1'b0;
   logic        meas_valid;
   logic [15:0] period;
   logic [15:0] high_time;
   logic [15:0] jitter;
   logic        period_err;
   logic        duty_err;
   logic        stuck;
   logic [15:0] max_jitter;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic [15:0] per;
      logic [15:0] hi;
      logic [15:0] jit;
      logic        perr;
      logic        derr;
   } meas_t;

   meas_t       cap[$];
   logic [15:0] cap_mj[$];
   int          cap_t[$];

   clk_period_monitor #(
      .CNT_W(16), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(TOLV), .TIMEOUT(64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mon_in     (mon_in),
      .meas_valid (meas_valid),
      .period     (period),
      .high_time  (high_time),
      .jitter     (jitter),
      .period_err (period_err),
      .duty_err   (duty_err),
      .stuck      (stuck),
      .max_jitter (max_jitter)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (meas_valid === 1'b1) begin
         cap.push_back('{period, high_time, jitter, period_err, duty_err});
         cap_mj.push_back(max_jitter);
         cap_t.push_back(cyc);
      end
   end

   // Expected result of one complete period, straight from the measurement rules.
   function automatic meas_t expect_meas(int h, int l);
      meas_t m;
      int p  = h + l;
      int jd = (p > EXP_P) ? p - EXP_P : EXP_P - p;
      int hd = (h > EXP_H) ? h - EXP_H : EXP_H - h;
      m.per  = 16'(p);
      m.hi   = 16'(h);
      m.jit  = 16'(jd);
      m.perr = (jd > TOLV);
      m.derr = (hd > TOLV);
      return m;
   endfunction

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_scenario();
      enable = 1'b0;
      mon_in = 1'b0;
      tick(4);
      cap.delete();
      cap_mj.delete();
      cap_t.delete();
      enable = 1'b1;
      tick(3);
   endtask

   task automatic drive_period(int h, int l);
      mon_in = 1'b1;
      tick(h);
      mon_in = 1'b0;
      tick(l);
   endtask

   task automatic close_period();
      mon_in = 1'b1;
      tick(5);
   endtask

   task automatic test_reset();
      mon_in = 1'b1;
      rst = 1'b1;
      tick(3);
      checks++;
      if ({meas_valid, period_err, duty_err, stuck} !== 4'b0)
         $display("FAIL reset_flags: got %b required 0000", {meas_valid, period_err, duty_err, stuck});
      checks++;
      if ({period, high_time, jitter, max_jitter} !== 64'd0)
         $display("FAIL reset_values: got per=%0d hi=%0d jit=%0d mj=%0d required all 0",
                  period, high_time, jitter, max_jitter);
      if ({period, high_time, jitter, max_jitter} !== 64'd0 ||
          {meas_valid, period_err, duty_err, stuck} !== 4'b0) errors++;
      rst = 1'b0;
      mon_in = 1'b0;
      tick(2);
   endtask

   task automatic test_patterns();
      int ph[3] = '{5, 5, 8};
      int pl[3] = '{5, 7, 2};
      meas_t e;
      for (int p = 0; p < 3; p++) begin
         start_scenario();
         repeat (3) drive_period(ph[p], pl[p]);
         close_period();
         e = expect_meas(ph[p], pl[p]);
         checks++;
         if (cap.size() != 3) begin
            errors++;
            $display("FAIL pattern%0d_count: got %0d required 3", p, cap.size());
         end
         for (int i = 0; i < cap.size() && i < 3; i++) begin
            checks++;
            if (cap[i] !== e) begin
               errors++;
               $display("FAIL pattern%0d_meas%0d: got per=%0d hi=%0d jit=%0d perr=%b derr=%b required per=%0d hi=%0d jit=%0d perr=%b derr=%b",
                        p, i, cap[i].per, cap[i].hi, cap[i].jit, cap[i].perr, cap[i].derr,
                        e.per, e.hi, e.jit, e.perr, e.derr);
            end
         end
         for (int i = 1; i < cap_t.size(); i++) begin
            checks++;
            if (cap_t[i] - cap_t[i-1] != ph[p] + pl[p]) begin
               errors++;
               $display("FAIL pattern%0d_spacing%0d: got %0d cycles required %0d",
                        p, i, cap_t[i] - cap_t[i-1], ph[p] + pl[p]);
            end
         end
      end
   endtask

   task automatic test_random();
      int hs[$];
      int ls[$];
      meas_t e;
      start_scenario();
      for (int i = 0; i < 10; i++) begin
         hs.push_back(int'($urandom_range(12, 1)));
         ls.push_back(int'($urandom_range(12, 1)));
         drive_period(hs[i], ls[i]);
      end
      close_period();
      checks++;
      if (cap.size() != 10) begin
         errors++;
         $display("FAIL random_count: got %0d required 10", cap.size());
      end
      for (int i = 0; i < cap.size() && i < 10; i++) begin
         e = expect_meas(hs[i], ls[i]);
         checks++;
         if (cap[i] !== e) begin
            errors++;
            $display("FAIL random_meas%0d: got per=%0d hi=%0d jit=%0d perr=%b derr=%b required per=%0d hi=%0d jit=%0d perr=%b derr=%b",
                     i, cap[i].per, cap[i].hi, cap[i].jit, cap[i].perr, cap[i].derr,
                     e.per, e.hi, e.jit, e.perr, e.derr);
         end
      end
   endtask

   task automatic test_stuck();
      meas_t e = expect_meas(5, 5);
      start_scenario();
      drive_period(5, 5);
      mon_in = 1'b1;
      tick(5);
      mon_in = 1'b0;
      tick(60);
      checks++;
      if (stuck !== 1'b0) begin
         errors++;
         $display("FAIL stuck_early: got %b required 0", stuck);
      end
      tick(10);
      checks++;
      if (stuck !== 1'b1) begin
         errors++;
         $display("FAIL stuck_set: got %b required 1", stuck);
      end
      checks++;
      if (cap.size() != 1) begin
         errors++;
         $display("FAIL stuck_no_meas: got %0d results required 1", cap.size());
      end
      cap.delete();
      mon_in = 1'b1;
      tick(4);
      checks++;
      if (stuck !== 1'b0) begin
         errors++;
         $display("FAIL stuck_clear: got %b required 0", stuck);
      end
      tick(1);
      mon_in = 1'b0;
      tick(5);
      repeat (2) drive_period(5, 5);
      close_period();
      checks++;
      if (cap.size() != 3) begin
         errors++;
         $display("FAIL stuck_recover_count: got %0d required 3", cap.size());
      end
      for (int i = 0; i < cap.size() && i < 3; i++) begin
         checks++;
         if (cap[i] !== e) begin
            errors++;
            $display("FAIL stuck_recover%0d: got per=%0d hi=%0d required per=%0d hi=%0d",
                     i, cap[i].per, cap[i].hi, e.per, e.hi);
         end
      end
   endtask

   task automatic test_rst_mid();
      meas_t e = expect_meas(5, 5);
      start_scenario();
      repeat (2) drive_period(5, 5);
      mon_in = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if ({meas_valid, period_err, duty_err, stuck} !== 4'b0 ||
          {period, high_time, jitter, max_jitter} !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_clear: got vld=%b per=%0d hi=%0d jit=%0d stuck=%b mj=%0d required all 0",
                  meas_valid, period, high_time, jitter, stuck, max_jitter);
      end
      cap.delete();
      tick(2);
      mon_in = 1'b0;
      tick(5);
      repeat (2) drive_period(5, 5);
      close_period();
      checks++;
      if (cap.size() != 3) begin
         errors++;
         $display("FAIL rst_mid_count: got %0d required 3", cap.size());
      end else begin
         checks++;
         if (cap[0].per !== cap[0].hi + 16'd5 || cap[0].hi > 16'd5) begin
            errors++;
            $display("FAIL rst_mid_partial: got per=%0d hi=%0d required per=hi+5 with hi<=5",
                     cap[0].per, cap[0].hi);
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (cap[i] !== e) begin
               errors++;
               $display("FAIL rst_mid_meas%0d: got per=%0d hi=%0d required per=%0d hi=%0d",
                        i, cap[i].per, cap[i].hi, e.per, e.hi);
            end
         end
      end
   endtask

   task automatic test_enable_abort();
      meas_t e = expect_meas(6, 5);
      start_scenario();
      repeat (2) drive_period(6, 5);
      close_period();
      cap.delete();
      mon_in = 1'b0;
      tick(3);
      enable = 1'b0;
      tick(3);
      drive_period(5, 5);
      mon_in = 1'b1;
      tick(5);
      checks++;
      if (cap.size() != 0) begin
         errors++;
         $display("FAIL abort_no_meas: got %0d results required 0", cap.size());
      end
      checks++;
      if (period !== e.per || high_time !== e.hi || jitter !== e.jit) begin
         errors++;
         $display("FAIL abort_hold: got per=%0d hi=%0d jit=%0d required per=%0d hi=%0d jit=%0d",
                  period, high_time, jitter, e.per, e.hi, e.jit);
      end
      enable = 1'b1;
      tick(2);
      mon_in = 1'b0;
      tick(5);
      drive_period(5, 5);
      close_period();
      e = expect_meas(5, 5);
      checks++;
      if (cap.size() != 1 || cap[0] !== e) begin
         errors++;
         $display("FAIL reenable_first: got %0d results per=%0d required 1 result per=%0d",
                  cap.size(), (cap.size() > 0) ? cap[0].per : 16'd0, e.per);
      end
   endtask

   task automatic test_maxjit();
      int ls[3] = '{5, 8, 4};
      int mx = 0;
      int jd;
      enable = 1'b0;
      mon_in = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      cap.delete();
      cap_mj.delete();
      enable = 1'b1;
      tick(3);
      for (int i = 0; i < 3; i++) drive_period(5, ls[i]);
      close_period();
      checks++;
      if (cap_mj.size() != 3) begin
         errors++;
         $display("FAIL maxjit_count: got %0d required 3", cap_mj.size());
      end
      for (int i = 0; i < cap_mj.size() && i < 3; i++) begin
         jd = (5 + ls[i] > EXP_P) ? 5 + ls[i] - EXP_P : EXP_P - 5 - ls[i];
`ifdef CLK_MON_MAXJIT_EN
         if (jd > mx) mx = jd;
`endif
         checks++;
         if (cap_mj[i] !== 16'(mx)) begin
            errors++;
            $display("FAIL maxjit%0d: got %0d required %0d", i, cap_mj[i], mx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_random();
      test_stuck();
      test_enable_abort();
      test_rst_mid();
      test_maxjit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
